// File: rtl/regfile_wb_arbiter_if.sv
// FPU result handshake into the register-file writeback arbiter.
// The FPU side drives valid/register/data; the arbiter answers with ready.
interface regfile_wb_arbiter_if;
  logic        f_valid;
  logic        f_ready;
  logic [4:0]  f_wn;
  logic [31:0] f_d;

  modport master (output f_valid, output f_wn, output f_d, input f_ready);
  modport slave  (input f_valid, input f_wn, input f_d, output f_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback (priority) and queued FPU results onto the single regfile
// write port, with a pending-register scoreboard. Optional forwarding: `define WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  p_we,
  input  logic [4:0]            p_wn,
  input  logic [31:0]           p_d,
  regfile_wb_arbiter_if.slave   fpu,
  input  logic                  iss_en,
  input  logic [4:0]            iss_wn,
  input  logic                  flush,
  input  logic [4:0]            chk_rna,
  input  logic [4:0]            chk_rnb,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  we,
  output logic [4:0]            wn,
  output logic [31:0]           d,
  output logic [AW:0]           count,
  output logic                  byp_hit_a,
  output logic                  byp_hit_b,
  output logic [31:0]           byp_d
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          src_fifo;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic          p_valid;
  logic          empty;
  logic          push;
  logic          pop;
  logic [36:0]   head;

  assign p_valid     = p_we && (p_wn != 5'd0);
  assign empty       = (count == '0);
  assign fpu.f_ready = (count != FULL);
  assign push        = fpu.f_valid && fpu.f_ready;
  assign pop         = !p_valid && !empty;
  // Gate the read so an empty FIFO never feeds stale or X data forward.
  assign head        = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {fpu.f_wn, fpu.f_d};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: the regfile captures wn/d one edge after we rises here
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we       <= 1'b0;
      wn       <= '0;
      d        <= '0;
      src_fifo <= 1'b0;
    end else if (flush) begin
      we       <= 1'b0;
      src_fifo <= 1'b0;
    end else if (p_valid) begin
      we       <= 1'b1;
      wn       <= p_wn;
      d        <= p_d;
      src_fifo <= 1'b0;
    end else if (!empty) begin
      we       <= (head[36:32] != 5'd0);
      wn       <= head[36:32];
      d        <= head[31:0];
      src_fifo <= 1'b1;
    end else begin
      we       <= 1'b0;
      src_fifo <= 1'b0;
    end
  end

  // Set is applied after clear so an issue wins over a same-edge retirement.
  always_comb begin
    pending_nxt = pending;
    if (we && src_fifo) pending_nxt[wn] = 1'b0;
    if (iss_en)         pending_nxt[iss_wn] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)      pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= pending_nxt;
  end

  assign busy_a = pending[chk_rna];
  assign busy_b = pending[chk_rnb];

`ifdef WB_BYPASS_EN
  assign byp_hit_a = we && (wn != 5'd0) && (wn == chk_rna);
  assign byp_hit_b = we && (wn != 5'd0) && (wn == chk_rnb);
  assign byp_d     = d;
`else
  assign byp_hit_a = 1'b0;
  assign byp_hit_b = 1'b0;
  assign byp_d     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, priority, FIFO back-pressure, scoreboard, flush.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        clrn;
  logic        p_we;
  logic [4:0]  p_wn;
  logic [31:0] p_d;
  logic        iss_en;
  logic [4:0]  iss_wn;
  logic        flush;
  logic [4:0]  chk_rna;
  logic [4:0]  chk_rnb;
  logic        busy_a;
  logic        busy_b;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [2:0]  count;
  logic        byp_hit_a;
  logic        byp_hit_b;
  logic [31:0] byp_d;

  int passed = 0;
  int total  = 0;

  regfile_wb_arbiter_if fpu_bus ();

  regfile_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .clrn(clrn),
    .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
    .fpu(fpu_bus.slave),
    .iss_en(iss_en), .iss_wn(iss_wn), .flush(flush),
    .chk_rna(chk_rna), .chk_rnb(chk_rnb),
    .busy_a(busy_a), .busy_b(busy_b),
    .we(we), .wn(wn), .d(d), .count(count),
    .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b), .byp_d(byp_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    clrn = 1'b1;
    p_we = 0; p_wn = 0; p_d = 0;
    iss_en = 0; iss_wn = 0; flush = 0;
    chk_rna = 0; chk_rnb = 0;
    fpu_bus.f_valid = 0; fpu_bus.f_wn = 0; fpu_bus.f_d = 0;
    #2 clrn = 1'b0;
    #2;
    chk("rst_we", we, 0);
    chk("rst_count", count, 0);
    chk("rst_f_ready", fpu_bus.f_ready, 1);
    chk("rst_busy_a", busy_a, 0);
    tick();
    clrn = 1'b1;
    tick();

    // pipeline write, then p_wn=0 is ignored
    p_we = 1; p_wn = 5; p_d = 32'hDEADBEEF;
    tick();
    chk("pipe_we", we, 1);
    chk("pipe_wn", wn, 5);
    chk("pipe_d", d, 32'hDEADBEEF);
    p_wn = 0; p_d = 32'h0BAD0BAD;
    tick();
    chk("pipe_r0_we", we, 0);
    chk("pipe_r0_wn_hold", wn, 5);
    chk("pipe_r0_d_hold", d, 32'hDEADBEEF);

    // bypass outputs
    p_wn = 4; p_d = 32'h12345678;
    tick();
    p_we = 0;
    chk_rna = 0; chk_rnb = 4;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_hit_b", byp_hit_b, 1);
    chk("byp_hit_a_r0", byp_hit_a, 0);
    chk("byp_d", byp_d, 32'h12345678);
`else
    chk("byp_hit_b_off", byp_hit_b, 0);
    chk("byp_hit_a_off", byp_hit_a, 0);
    chk("byp_d_off", byp_d, 0);
`endif
    tick();

    // issue 7, FPU result one cycle later
    iss_en = 1; iss_wn = 7; chk_rna = 7;
    tick();
    iss_en = 0;
    chk("sb_busy_after_issue", busy_a, 1);
    fpu_bus.f_valid = 1; fpu_bus.f_wn = 7; fpu_bus.f_d = 32'h3F800000;
    tick();
    fpu_bus.f_valid = 0;
    chk("fpu_count1", count, 1);
    chk("fpu_we_not_yet", we, 0);
    chk("fpu_busy_held", busy_a, 1);
    tick();
    chk("fpu_we", we, 1);
    chk("fpu_wn", wn, 7);
    chk("fpu_d", d, 32'h3F800000);
    chk("fpu_count0", count, 0);
    tick();
    chk("fpu_busy_cleared", busy_a, 0);
    chk("fpu_we_off", we, 0);

    // starvation and back-pressure: pipeline holds the port while 5 results arrive
    p_we = 1; p_wn = 1; p_d = 32'h11;
    fpu_bus.f_valid = 1;
    for (int i = 0; i < 4; i++) begin
      fpu_bus.f_wn = 5'(10 + i); fpu_bus.f_d = 32'hA0 + 32'(i);
      tick();
    end
    chk("bp_count_full", count, 4);
    chk("bp_f_ready_low", fpu_bus.f_ready, 0);
    fpu_bus.f_wn = 14; fpu_bus.f_d = 32'hA4;
    tick();
    tick();
    chk("bp_held_count", count, 4);
    chk("bp_pipe_wn", wn, 1);
    p_we = 0;
    tick();
    chk("bp_pop0_wn", wn, 10);
    chk("bp_pop0_d", d, 32'hA0);
    chk("bp_pop0_count", count, 3);
    chk("bp_ready_again", fpu_bus.f_ready, 1);
    tick();
    fpu_bus.f_valid = 0;
    chk("bp_pop1_wn", wn, 11);
    chk("bp_pushpop_count", count, 3);
    tick();
    chk("bp_pop2_wn", wn, 12);
    tick();
    chk("bp_pop3_wn", wn, 13);
    tick();
    chk("bp_pop4_wn", wn, 14);
    chk("bp_pop4_d", d, 32'hA4);
    chk("bp_empty", count, 0);
    tick();
    chk("bp_idle_we", we, 0);

    // priority with two entries queued
    p_we = 1; p_wn = 2; p_d = 32'hC2;
    fpu_bus.f_valid = 1; fpu_bus.f_wn = 20; fpu_bus.f_d = 32'hB0;
    tick();
    fpu_bus.f_wn = 21; fpu_bus.f_d = 32'hB1;
    tick();
    fpu_bus.f_valid = 0;
    chk("pri_count2", count, 2);
    p_wn = 3; p_d = 32'hC3;
    tick();
    p_we = 0;
    chk("pri_pipe_wn", wn, 3);
    chk("pri_pipe_d", d, 32'hC3);
    tick();
    chk("pri_fifo0_wn", wn, 20);
    chk("pri_fifo0_d", d, 32'hB0);
    tick();
    chk("pri_fifo1_wn", wn, 21);
    chk("pri_count0", count, 0);
    tick();

    // flush with three queued results and pending {8,9,10}
    p_we = 1; p_wn = 2; p_d = 32'hC2;
    fpu_bus.f_valid = 1;
    iss_en = 1;
    for (int i = 0; i < 3; i++) begin
      iss_wn = 5'(8 + i);
      fpu_bus.f_wn = 5'(8 + i); fpu_bus.f_d = 32'hE0 + 32'(i);
      tick();
    end
    fpu_bus.f_valid = 0;
    chk_rna = 8; chk_rnb = 10;
    iss_wn = 11;
    flush = 1;
    #1;
    chk("fl_pre_count", count, 3);
    chk("fl_pre_busy_a", busy_a, 1);
    chk("fl_pre_busy_b", busy_b, 1);
    tick();
    flush = 0; iss_en = 0; p_we = 0;
    chk("fl_count", count, 0);
    chk("fl_we", we, 0);
    chk("fl_busy_a8", busy_a, 0);
    chk("fl_busy_b10", busy_b, 0);
    chk_rna = 9; chk_rnb = 11;
    #1;
    chk("fl_busy_a9", busy_a, 0);
    chk("fl_busy_b11", busy_b, 0);
    tick();
    chk("fl_no_pop", we, 0);

    // asynchronous reset mid-run with count=3 and pending[7]
    p_we = 1; p_wn = 2; p_d = 32'hC2;
    fpu_bus.f_valid = 1; fpu_bus.f_wn = 7; fpu_bus.f_d = 32'h77;
    iss_en = 1; iss_wn = 7; chk_rna = 7;
    tick();
    iss_en = 0;
    tick();
    tick();
    fpu_bus.f_valid = 0;
    chk("ar_pre_count", count, 3);
    chk("ar_pre_busy", busy_a, 1);
    clrn = 0;
    #1;
    chk("ar_we", we, 0);
    chk("ar_wn", wn, 0);
    chk("ar_d", d, 0);
    chk("ar_count", count, 0);
    chk("ar_f_ready", fpu_bus.f_ready, 1);
    chk("ar_busy_a", busy_a, 0);
    p_we = 0;
    tick();
    clrn = 1;
    tick();
    chk("ar_after_we", we, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side controller for the 32x32 integer/FP register file, which has one write port (wn, d, we), two async read ports and reg 0 hardwired to zero.
- Merges two result sources onto that single write port:
  - the in-order pipeline writeback, which always gets priority;
  - the multi-cycle FPU, which uses a valid/ready handshake into a small result FIFO.
- Keeps a pending-register scoreboard so decode can stall reads of registers an outstanding FPU op will write.
- Flush (interrupt/exception entry) discards all queued FPU results and reservations.

Parameters:
DEPTH, 4, FPU result FIFO entries (power of two, >=2)
AW, 2, log2(DEPTH), FIFO pointer width

Ports:
clk  in  1  clock, rising edge
clrn  in  1  reset, asynchronous, active-low
p_we  in  1  pipeline writeback valid
p_wn  in  5  pipeline destination register
p_d  in  32  pipeline result data
f_valid  in  1  FPU result valid
f_ready  out  1  FIFO can accept FPU result
f_wn  in  5  FPU destination register
f_d  in  32  FPU result data
iss_en  in  1  FPU op issued; reserve iss_wn
iss_wn  in  5  register reserved at FPU issue
flush  in  1  synchronous discard of FIFO and reservations
chk_rna  in  5  decode source A to check
chk_rnb  in  5  decode source B to check
busy_a  out  1  chk_rna has an outstanding FPU write
busy_b  out  1  chk_rnb has an outstanding FPU write
we  out  1  regfile write enable (registered)
wn  out  5  regfile write register (registered)
d  out  32  regfile write data (registered)
count  out  AW+1  FIFO occupancy
byp_hit_a  out  1  output stage writes chk_rna (see optional feature)
byp_hit_b  out  1  output stage writes chk_rnb
byp_d  out  32  output-stage data for bypass

Behaviour:
- Reset (clrn=0, asynchronous):
  - we=0, wn=0, d=0;
  - FIFO pointers and count are 0, so f_ready=1;
  - all pending bits are 0, so busy_a=busy_b=0;
  - the internal src_fifo flag is 0.
- A pipeline write is valid when p_we=1 and p_wn!=0. p_we with p_wn=0 is treated as no pipeline write.
- Source select, evaluated every cycle; the chosen source loads wn/d/we at the next edge (latency 1):
  - valid pipeline write: we<=1, wn<=p_wn, d<=p_d, src_fifo<=0;
  - else FIFO non-empty: pop head, we<=1, wn/d<=head entry, src_fifo<=1;
  - else: we<=0, src_fifo<=0; wn/d hold their previous values.
- FIFO and handshake:
  - f_ready = (count != DEPTH), computed combinationally from count.
  - Push occurs when f_valid && f_ready.
  - A full FIFO refuses a push even in a pop cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
  - Pointers wrap modulo DEPTH. Entries pop in push order.
  - Minimum FPU latency is 2 edges from accept to we=1 (FIFO, then output register).
  - An FPU result with f_wn=0 is pushed and popped but drives we=0.
- Scoreboard (pending[31:1]):
  - Set at the edge where iss_en=1 and iss_wn!=0.
  - Cleared for wn at the edge where we=1 and src_fifo=1, i.e. the same edge the regfile captures the data.
  - Set and clear of the same register on the same edge: set wins.
  - Pipeline writes never change pending.
  - busy_a = pending[chk_rna], combinational; register 0 is never busy. busy_b is the same for chk_rnb.
- Flush (synchronous, highest priority):
  - next edge: count=0, pointers=0, all pending=0, we=0, src_fifo=0;
  - iss_en, push and pop in the flush cycle are ignored.
- Starvation: continuous pipeline writes may stall the FIFO indefinitely. The FPU back-pressures via f_ready; no data is lost.
- No X propagation: the FIFO read is gated by non-empty.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined:
  - byp_hit_a = we && wn!=0 && wn==chk_rna; byp_hit_b is the same for chk_rnb; byp_d = d.
  - This lets decode forward data that the regfile captures only at the next edge.
- When undefined:
  - byp_hit_a=byp_hit_b=0 and byp_d=0 constantly;
  - the ports remain present so integration is unchanged.

Test Plan:
- Assert clrn=0 mid-run with FIFO count=3 and pending[7]=1 -> immediately we=0, wn=0, d=0, count=0, f_ready=1, busy_a=0 (chk_rna=7).
- Pipeline write p_we=1, p_wn=5, p_d=32'hDEADBEEF -> next cycle we=1, wn=5, d=32'hDEADBEEF. Same with p_wn=0 -> we=0.
- iss_en with iss_wn=7, then f_valid with f_wn=7, f_d=32'h3F800000 one cycle later:
  - busy_a=1 (chk_rna=7) from the edge after issue;
  - we=1, wn=7, d=32'h3F800000 two edges after accept;
  - busy_a=0 the cycle after that.
- Hold p_we=1 (p_wn=1) while pushing 5 FPU results with f_wn=10..14:
  - f_ready=0 after the 4th accept; the 5th is held;
  - release p_we -> writes to 10, 11, 12, 13 in order; f_ready=1 the cycle after the first pop; 14 is accepted then written.
- With FIFO count=2, assert p_we (p_wn=3) -> pipeline write to 3 first; FIFO entries follow on the next two cycles.
- With FIFO count=3 and pending bits {8,9,10} set, pulse flush together with iss_en (iss_wn=11) -> next cycle count=0, we=0, all busy=0, pending[11]=0.
  - With WB_BYPASS_EN: we=1, wn=4, chk_rnb=4 -> byp_hit_b=1, byp_d=d.
